// File: rtl/vec_op_sequencer.sv
// Streams operand pairs from banks A/B through the combinational vector ALU into the result bank.
// Latency: read in cycle c, result write in cycle c+3; one element per clock, done pulse at cycle len+4.
// Backpressure: none downstream; abort cancels reads/writes the same cycle, start is taken only in IDLE.
module vec_op_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        opcode_in,
    input  logic [ADDR_W:0]   len_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic [DATA_W-1:0] mu_in,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_a_data,
    input  logic [DATA_W-1:0] rd_b_data,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    output logic [DATA_W-1:0] alu_q,
    output logic [DATA_W-1:0] alu_mu,
    input  logic [DATA_W-1:0] alu_res,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0]      OP_MULT = 3'b010;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rd_cnt;

    // Pipeline: dat_* = bank data arriving, alu_* = operands at the ALU, wr_vld = result staged.
    logic              dat_vld;
    logic [ADDR_W-1:0] dat_addr;
    logic              alu_vld;
    logic [ADDR_W-1:0] alu_addr;
    logic              wr_vld;

    logic              accept;
    logic              legal;
    logic              kill;
    logic              last_rd;
    logic              last_wr;

    assign accept  = (state == ST_IDLE) && start;
    assign legal   = (opcode_in <= OP_MULT);
    assign kill    = abort && ((state == ST_RUN) || (state == ST_DRAIN));
    assign last_rd = ((rd_cnt + CNT_ONE) == len_q);
    assign last_wr = wr_vld && !alu_vld && !dat_vld;

    assign rd_en   = (state == ST_RUN) && !abort;
    assign rd_addr = rd_cnt[ADDR_W-1:0];
    assign wr_en   = wr_vld && !kill;
    assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!legal || (len_in == '0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else if (last_rd) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else if (last_wr) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept && !legal;
        end
    end

    // Command registers hold until the next accepted start, illegal ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_q      <= '0;
            alu_mu     <= '0;
            len_q      <= '0;
        end else if (accept) begin
            alu_opcode <= opcode_in;
            alu_q      <= q_in;
            alu_mu     <= mu_in;
            len_q      <= len_in;
        end
    end

    // The counter stops on the last address so a full-length run never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (accept) begin
            rd_cnt <= '0;
        end else if (rd_en && !last_rd) begin
            rd_cnt <= rd_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_vld <= 1'b0;
            alu_vld <= 1'b0;
            wr_vld  <= 1'b0;
        end else begin
            dat_vld <= rd_en;
            alu_vld <= dat_vld && !kill;
            wr_vld  <= alu_vld && !kill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_addr <= '0;
            alu_addr <= '0;
            wr_addr  <= '0;
            alu_op_a <= '0;
            alu_op_b <= '0;
            wr_data  <= '0;
        end else begin
            if (rd_en) begin
                dat_addr <= rd_addr;
            end
            if (dat_vld) begin
                alu_addr <= dat_addr;
                alu_op_a <= rd_a_data;
                alu_op_b <= rd_b_data;
            end
            if (alu_vld) begin
                wr_addr <= alu_addr;
                wr_data <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Directed bench for vec_op_sequencer: table of commands plus abort, reset and start-hold sequences.
module tb_vec_op_sequencer;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int NV = 7;
    localparam logic [DW-1:0] MU17 = 64'h0F0F_0F0F_0F0F_0F0F;

    typedef struct {
        logic [2:0]            op;
        int                    len;
        logic [DW-1:0]         q;
        logic [DW-1:0]         mu;
        logic [15:0][DW-1:0]   a;
        logic [15:0][DW-1:0]   b;
        logic [15:0][DW-1:0]   exp;
    } vec_t;

    vec_t vt [NV];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    opcode_in;
    logic [AW:0]   len_in;
    logic [DW-1:0] q_in;
    logic [DW-1:0] mu_in;
    logic          abort;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_a_data = '0;
    logic [DW-1:0] rd_b_data = '0;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_op_a;
    logic [DW-1:0] alu_op_b;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] alu_mu;
    logic [DW-1:0] alu_res;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [127:0]  wa, wb, wq, wres;

    int n_chk  = 0;
    int n_fail = 0;

    vec_op_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode_in(opcode_in),
        .len_in(len_in), .q_in(q_in), .mu_in(mu_in), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .alu_opcode(alu_opcode), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_q(alu_q), .alu_mu(alu_mu), .alu_res(alu_res),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Operand banks: synchronous read, data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= mem_a[rd_addr];
            rd_b_data <= mem_b[rd_addr];
        end
    end

    // Reference modular ALU.
    always_comb begin
        wa   = {64'b0, alu_op_a};
        wb   = {64'b0, alu_op_b};
        wq   = {64'b0, alu_q};
        wres = '0;
        if (alu_q != '0) begin
            case (alu_opcode)
                3'b000:  wres = (wa + wb) % wq;
                3'b001:  wres = (wa + wq - (wb % wq)) % wq;
                3'b010:  wres = (wa * wb) % wq;
                default: wres = '0;
            endcase
        end
        alu_res = wres[DW-1:0];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " rd_en"},   DW'(rd_en),   '0);
        chk({tag, " wr_en"},   DW'(wr_en),   '0);
        chk({tag, " busy"},    DW'(busy),    '0);
        chk({tag, " done"},    DW'(done),    '0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle_outputs(tag);
        chk({tag, " err"},        DW'(err),        '0);
        chk({tag, " rd_addr"},    DW'(rd_addr),    '0);
        chk({tag, " wr_addr"},    DW'(wr_addr),    '0);
        chk({tag, " wr_data"},    wr_data,         '0);
        chk({tag, " alu_op_a"},   alu_op_a,        '0);
        chk({tag, " alu_op_b"},   alu_op_b,        '0);
        chk({tag, " alu_q"},      alu_q,           '0);
        chk({tag, " alu_mu"},     alu_mu,          '0);
        chk({tag, " alu_opcode"}, DW'(alu_opcode), '0);
    endtask

    task automatic check_cycle(input int v, input int k, input vec_t t);
        bit    legal, act, e_rd, e_wr, e_busy, e_done, e_err;
        string p;
        p      = $sformatf("v%0d c%0d", v, k);
        legal  = (t.op <= 3'b010);
        act    = legal && (t.len > 0);
        e_rd   = act && (k >= 1) && (k <= t.len);
        e_wr   = act && (k >= 4) && (k <= t.len + 3);
        e_busy = act && (k >= 1) && (k <= t.len + 3);
        e_done = act ? (k == t.len + 4) : (k == 1);
        e_err  = !legal && (k == 1);
        chk({p, " rd_en"}, DW'(rd_en), DW'(e_rd));
        chk({p, " wr_en"}, DW'(wr_en), DW'(e_wr));
        chk({p, " busy"},  DW'(busy),  DW'(e_busy));
        chk({p, " done"},  DW'(done),  DW'(e_done));
        chk({p, " err"},   DW'(err),   DW'(e_err));
        if (e_rd) chk({p, " rd_addr"}, DW'(rd_addr), DW'(k - 1));
        if (e_wr) begin
            chk({p, " wr_addr"}, DW'(wr_addr), DW'(k - 4));
            chk({p, " wr_data"}, wr_data, t.exp[k - 4]);
        end
        if (k >= 1) chk({p, " alu_mu"}, alu_mu, t.mu);
    endtask

    task automatic start_cmd(input logic [2:0] op, input int len, input logic [DW-1:0] q,
                             input logic [DW-1:0] mu);
        start     = 1'b1;
        opcode_in = op;
        len_in    = (AW + 1)'(len);
        q_in      = q;
        mu_in     = mu;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = 64'd1;
        end
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        t = vt[v];
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = t.a[i];
            mem_b[i] = t.b[i];
        end
        @(negedge clk);
        start_cmd(t.op, t.len, t.q, t.mu);
        for (int k = 0; k <= t.len + 6; k++) begin
            if (k == 1) start = 1'b0;
            #1;
            check_cycle(v, k, t);
            @(negedge clk);
        end
        chk($sformatf("v%0d alu_opcode", v), DW'(alu_opcode), DW'(t.op));
        chk($sformatf("v%0d alu_q", v), alu_q, t.q);
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            vt[v].a   = '0;
            vt[v].b   = '0;
            vt[v].exp = '0;
            vt[v].q   = 64'd17;
            vt[v].mu  = MU17;
        end
        vt[0].op = 3'b000; vt[0].len = 4;
        vt[0].a[0] = 10; vt[0].a[1] = 15; vt[0].a[2] = 3;  vt[0].a[3] = 0;
        vt[0].b[0] = 9;  vt[0].b[1] = 2;  vt[0].b[2] = 16; vt[0].b[3] = 0;
        vt[0].exp[0] = 2; vt[0].exp[1] = 0; vt[0].exp[2] = 2; vt[0].exp[3] = 0;
        vt[1].op = 3'b001; vt[1].len = 2;
        vt[1].a[0] = 3;  vt[1].a[1] = 10;
        vt[1].b[0] = 5;  vt[1].b[1] = 4;
        vt[1].exp[0] = 15; vt[1].exp[1] = 6;
        vt[2].op = 3'b010; vt[2].len = 3;
        vt[2].a[0] = 4;  vt[2].a[1] = 16; vt[2].a[2] = 0;
        vt[2].b[0] = 5;  vt[2].b[1] = 16; vt[2].b[2] = 9;
        vt[2].exp[0] = 3; vt[2].exp[1] = 1; vt[2].exp[2] = 0;
        vt[3].op = 3'b000; vt[3].len = 0;
        vt[4].op = 3'b101; vt[4].len = 4; vt[4].a[0] = 1; vt[4].b[0] = 1;
        vt[5].op = 3'b111; vt[5].len = 0; vt[5].q = 64'd5; vt[5].mu = 64'd1234;
        vt[6].op = 3'b000; vt[6].len = 16;
        for (int i = 0; i < 16; i++) begin
            vt[6].a[i]   = DW'(i);
            vt[6].b[i]   = DW'(i + 1);
            vt[6].exp[i] = DW'((2 * i + 1) % 17);
        end

        rst_n = 1'b0; abort = 1'b0;
        start_cmd(3'b000, 0, '0, '0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) run_vec(v);

        // Abort in cycle 3 of a len=8 run, then a fresh run must still complete.
        load_ramp();
        @(negedge clk);
        start_cmd(3'b000, 8, 64'd17, MU17);
        for (int k = 0; k <= 12; k++) begin
            if (k == 1) start = 1'b0;
            if (k == 3) abort = 1'b1;
            if (k == 4) abort = 1'b0;
            #1;
            if (k == 2) chk("abort c2 rd_en", DW'(rd_en), 64'd1);
            if (k == 3) begin
                chk("abort c3 rd_en", DW'(rd_en), '0);
                chk("abort c3 wr_en", DW'(wr_en), '0);
            end
            if (k >= 4) check_idle_outputs($sformatf("abort c%0d", k));
            @(negedge clk);
        end
        run_vec(0);

        // Reset pulsed in cycle 5 of a len=8 run.
        load_ramp();
        @(negedge clk);
        start_cmd(3'b000, 8, 64'd17, MU17);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) start = 1'b0;
            @(negedge clk);
        end
        #1;
        chk("rst c5 wr_en before", DW'(wr_en), 64'd1);
        chk("rst c5 wr_data before", wr_data, 64'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst c5");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check_idle_outputs($sformatf("post-rst %0d", k));
            @(negedge clk);
        end

        // start held high through a len=2 run: second run accepted in cycle 7.
        load_ramp();
        @(negedge clk);
        start_cmd(3'b000, 2, 64'd17, MU17);
        for (int k = 0; k <= 14; k++) begin
            if (k == 8) start = 1'b0;
            #1;
            chk($sformatf("hold c%0d rd_en", k), DW'(rd_en),
                DW'(k == 1 || k == 2 || k == 8 || k == 9));
            chk($sformatf("hold c%0d busy", k), DW'(busy),
                DW'((k >= 1 && k <= 5) || (k >= 8 && k <= 12)));
            chk($sformatf("hold c%0d done", k), DW'(done), DW'(k == 6 || k == 13));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
